// File: rtl/rom_download_bridge.sv
// rtl/rom_download_bridge.sv - packs ioctl download bytes into 16-bit toggle-handshake ROM writes
// Optional feature macro: ROM_BITREV_EN (adds rom_bitrev input; bytes bit-reversed before packing)
module rom_download_bridge #(
  parameter int unsigned ADDR_W    = 22,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
`ifdef ROM_BITREV_EN
  input  logic              rom_bitrev,
`endif
  output logic              ioctl_wait,
  output logic [20:0]       rom_addr,
  output logic [15:0]       rom_din,
  output logic              rom_we,
  output logic              rom_req,
  input  logic              rom_req_ack,
  output logic [ADDR_W-1:0] dl_size,
  output logic              dl_done
);

  typedef enum logic [2:0] {IDLE, LOW, ISSUE, WAIT_ACK, FLUSH, DONE} state_t;

  state_t            state, state_d;
  logic              dl_prev, fall_pend;
  logic [7:0]        low_byte, byte_in;
  logic [20:0]       word_addr, wr_word;
  logic              wr_odd;
  logic [ADDR_W-1:0] size_acc, size_base, addr_end;
  logic [ADDR_W:0]   addr_p1;
  logic              dl_rise, dl_fall, end_req, ack_match, accept;
  logic              take_low, take_pair, take_orphan, do_issue, do_flush, do_done;

`ifdef ROM_BITREV_EN
  logic [7:0] byte_rev;

  // Mirror the byte (b0<->b7, b1<->b6, ...) for bit-reversed dumps
  always_comb begin
    for (int i = 0; i < 8; i++) byte_rev[i] = ioctl_dout[7-i];
  end

  assign byte_in = rom_bitrev ? byte_rev : ioctl_dout;
`else
  assign byte_in = ioctl_dout;
`endif

  assign wr_word   = ioctl_addr[21:1];
  assign wr_odd    = ioctl_addr[0];
  assign dl_rise   = ioctl_download & ~dl_prev;
  assign dl_fall   = dl_prev & ~ioctl_download;
  assign end_req   = fall_pend | dl_fall;
  assign ack_match = (rom_req_ack == rom_req);
  assign accept    = take_low | take_pair | take_orphan;

  // Image size is last accepted address + 1, clamped at the all-ones value
  assign addr_p1   = {1'b0, ioctl_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign addr_end  = addr_p1[ADDR_W] ? {ADDR_W{1'b1}} : addr_p1[ADDR_W-1:0];
  assign size_base = dl_rise ? '0 : size_acc;

  // State register
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= IDLE;
    else         state <= state_d;
  end

  // Next state and per-cycle action strobes; accepted bytes take priority over end-of-download
  always_comb begin
    state_d     = state;
    take_low    = 1'b0;
    take_pair   = 1'b0;
    take_orphan = 1'b0;
    do_issue    = 1'b0;
    do_flush    = 1'b0;
    do_done     = 1'b0;
    ioctl_wait  = 1'b0;
    case (state)
      IDLE: begin
        if (ioctl_wr && !wr_odd) begin
          take_low = 1'b1;
          state_d  = LOW;
        end else if (ioctl_wr) begin
          take_orphan = 1'b1;
          state_d     = ISSUE;
        end else if (end_req) begin
          state_d = DONE;
        end
      end
      LOW: begin
        // An odd byte for another word has no partner here and is discarded
        if (ioctl_wr && !wr_odd) begin
          take_low = 1'b1;
        end else if (ioctl_wr && wr_word == word_addr) begin
          take_pair = 1'b1;
          state_d   = ISSUE;
        end else if (end_req) begin
          state_d = FLUSH;
        end
      end
      ISSUE: begin
        ioctl_wait = 1'b1;
        do_issue   = 1'b1;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        ioctl_wait = 1'b1;
        if (ack_match) state_d = end_req ? DONE : IDLE;
      end
      FLUSH: begin
        ioctl_wait = 1'b1;
        do_flush   = 1'b1;
        state_d    = WAIT_ACK;
      end
      DONE: begin
        do_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Download edge tracking; a fall is remembered until the done pulse consumes it
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      dl_prev   <= 1'b0;
      fall_pend <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      if (do_done || dl_rise) fall_pend <= 1'b0;
      else if (dl_fall)       fall_pend <= 1'b1;
    end
  end

  // Even-byte latch and the word address of the word being assembled
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      low_byte  <= 8'h00;
      word_addr <= 21'd0;
    end else if (take_low) begin
      low_byte  <= byte_in;
      word_addr <= wr_word;
    end else if (take_orphan) begin
      word_addr <= wr_word;
    end
  end

  // ROM port: data is staged first, then address and request toggle go out together
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      rom_din  <= 16'h0000;
      rom_addr <= 21'd0;
      rom_we   <= 1'b0;
      rom_req  <= 1'b0;
    end else begin
      if (take_pair)   rom_din <= {byte_in, low_byte};
      if (take_orphan) rom_din <= {byte_in, FILL_BYTE};
      if (do_flush)    rom_din <= {FILL_BYTE, low_byte};
      if (do_issue || do_flush) begin
        rom_addr <= word_addr;
        rom_we   <= 1'b1;
        rom_req  <= ~rom_req;
      end else if (do_done) begin
        rom_we <= 1'b0;
      end
    end
  end

  // Image size accumulation and the completion report
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      size_acc <= '0;
      dl_size  <= '0;
      dl_done  <= 1'b0;
    end else begin
      if (accept && addr_end > size_base) size_acc <= addr_end;
      else                                size_acc <= size_base;
      if (do_done) dl_size <= size_acc;
      dl_done <= do_done;
    end
  end

endmodule

// File: tb/tb_rom_download_bridge.sv
// tb/tb_rom_download_bridge.sv - self-checking bench for rom_download_bridge
module tb_rom_download_bridge;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              init_n, ioctl_download, ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait, rom_we, rom_req, rom_req_ack, dl_done;
  logic [20:0]       rom_addr;
  logic [15:0]       rom_din;
  logic [ADDR_W-1:0] dl_size;
`ifdef ROM_BITREV_EN
  logic              rom_bitrev;
`endif

  always #5 clk = ~clk;

  rom_download_bridge #(.ADDR_W(ADDR_W), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .init_n(init_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
`ifdef ROM_BITREV_EN
    .rom_bitrev(rom_bitrev),
`endif
    .ioctl_wait(ioctl_wait), .rom_addr(rom_addr), .rom_din(rom_din), .rom_we(rom_we),
    .rom_req(rom_req), .rom_req_ack(rom_req_ack), .dl_size(dl_size), .dl_done(dl_done)
  );

  typedef struct packed {logic [20:0] addr; logic [15:0] din; logic we;} wr_t;
  wr_t writes_q[$];

  int   ack_delay = 4;
  bit   ack_hold  = 1'b0;
  int   ack_cnt;
  logic req_q;
  int   tog_cnt = 0, proto_err = 0, done_cnt = 0, wait_hi = 0;
  int   n_cmp = 0, n_fail = 0;
  logic [7:0] img [64];

  // Controller model: capture each request, ack after ack_delay cycles, police the toggle protocol
  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      rom_req_ack <= 1'b0;
      ack_cnt     <= 0;
      req_q       <= 1'b0;
    end else begin
      req_q <= rom_req;
      if (rom_req != req_q) begin
        tog_cnt <= tog_cnt + 1;
        if (req_q != rom_req_ack) proto_err <= proto_err + 1;
      end
      if (rom_req != rom_req_ack) begin
        if (ack_cnt == 0) writes_q.push_back({rom_addr, rom_din, rom_we});
        if (!ack_hold && ack_cnt + 1 >= ack_delay) begin
          rom_req_ack <= rom_req;
          ack_cnt     <= 0;
        end else begin
          ack_cnt <= ack_cnt + 1;
        end
      end
    end
  end

  // Count done pulses and stall cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (dl_done)    done_cnt <= done_cnt + 1;
    if (ioctl_wait) wait_hi  <= wait_hi + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit drop_dl);
    int t = 0;
    while (ioctl_wait && t < 400) begin step(); t++; end
    check("wait_release", {31'd0, ioctl_wait}, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (drop_dl) ioctl_download = 1'b0;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (ioctl_wait && t < 400) begin step(); t++; end
    check("idle_reached", {31'd0, ioctl_wait}, 0);
  endtask

  task automatic wait_done(input int dbase);
    int t = 0;
    while (done_cnt == dbase && t < 400) begin step(); t++; end
    check("done_seen", (done_cnt > dbase) ? 1 : 0, 1);
    repeat (3) step();
  endtask

  task automatic check_word(input string name, input int k, input logic [20:0] a, input logic [15:0] d);
    if (k < writes_q.size()) begin
      check({name, "_addr"}, {11'd0, writes_q[k].addr}, {11'd0, a});
      check({name, "_din"}, {16'd0, writes_q[k].din}, {16'd0, d});
      check({name, "_we"}, {31'd0, writes_q[k].we}, 1);
    end else begin
      check({name, "_present"}, writes_q.size(), k + 1);
    end
  endtask

  task automatic run_download(input int start, input int n, input bit same_fall);
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < n; i++)
      send_byte(ADDR_W'(start + i), img[i], same_fall && (i == n - 1));
    ioctl_download = 1'b0;
  endtask

  // Reference: every word touched by [start, start+n) is written once; missing halves are 0xFF
  task automatic check_image(input int start, input int n, input int wbase, input int dbase);
    int first_w = start / 2;
    int last_w  = (start + n - 1) / 2;
    int k = wbase;
    check("n_writes", writes_q.size() - wbase, last_w - first_w + 1);
    for (int w = first_w; w <= last_w; w++) begin
      logic [7:0] lo, hi;
      lo = (2 * w >= start) ? img[2 * w - start] : 8'hFF;
      hi = (2 * w + 1 <= start + n - 1) ? img[2 * w + 1 - start] : 8'hFF;
      check_word("img", k, 21'(w), {hi, lo});
      k++;
    end
    check("dl_size", {10'd0, dl_size}, start + n);
    check("done_pulses", done_cnt - dbase, 1);
    check("we_after_done", {31'd0, rom_we}, 0);
    check("protocol", proto_err, 0);
  endtask

  typedef struct {
    logic [21:0] a;
    logic [7:0]  lo, hi;
    logic [20:0] exp_addr;
    logic [15:0] exp_din;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    logic [15:0] t2_exp [3];
    int wb, tb0, hb, db, st, nn;
    bit sf;

    vecs[0] = '{22'h000000, 8'h34, 8'h12, 21'h000000, 16'h1234};
    vecs[1] = '{22'h000002, 8'hAA, 8'h55, 21'h000001, 16'h55AA};
    vecs[2] = '{22'h000100, 8'h00, 8'hFF, 21'h000080, 16'hFF00};
    vecs[3] = '{22'h3FFFFE, 8'h01, 8'h02, 21'h1FFFFF, 16'h0201};
    t2_exp  = '{16'h0201, 16'h0403, 16'hFF05};

    init_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'h00;
`ifdef ROM_BITREV_EN
    rom_bitrev = 1'b0;
`endif
    repeat (3) step();
    init_n = 1'b1;
    step();
    check("rst_wait", {31'd0, ioctl_wait}, 0);
    check("rst_req", {31'd0, rom_req}, 0);
    check("rst_we", {31'd0, rom_we}, 0);
    check("rst_done", {31'd0, dl_done}, 0);
    check("rst_addr", {11'd0, rom_addr}, 0);
    check("rst_din", {16'd0, rom_din}, 0);
    check("rst_size", {10'd0, dl_size}, 0);

    // Single-word table, 4-cycle ack: one toggle and delay+2 stalled cycles per word
    db = done_cnt;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      wb = writes_q.size(); tb0 = tog_cnt; hb = wait_hi;
      send_byte(vecs[i].a, vecs[i].lo, 1'b0);
      send_byte(vecs[i].a + 22'd1, vecs[i].hi, 1'b0);
      wait_idle();
      check_word("vec", wb, vecs[i].exp_addr, vecs[i].exp_din);
      check("vec_toggles", tog_cnt - tb0, 1);
      check("vec_wait_cycles", wait_hi - hb, ack_delay + 2);
    end
    ioctl_download = 1'b0;
    wait_done(db);
    check("size_saturate", {10'd0, dl_size}, 32'h003FFFFF);
    check("vec_done_pulses", done_cnt - db, 1);

    // Five-byte odd image with trailing fill
    for (int i = 0; i < 5; i++) img[i] = 8'(i + 1);
    wb = writes_q.size(); db = done_cnt;
    run_download(0, 5, 1'b0);
    wait_done(db);
    check_image(0, 5, wb, db);
    for (int i = 0; i < 3; i++) check_word("five", wb + i, 21'(i), t2_exp[i]);

    // Ack withheld 50 cycles while the next byte waits
    wb = writes_q.size(); tb0 = tog_cnt; db = done_cnt;
    ioctl_download = 1'b1;
    step();
    ack_hold = 1'b1;
    send_byte(22'd0, 8'hA1, 1'b0);
    send_byte(22'd1, 8'hB2, 1'b0);
    repeat (50) step();
    check("hold_wait", {31'd0, ioctl_wait}, 1);
    check("hold_toggles", tog_cnt - tb0, 1);
    ack_hold = 1'b0;
    send_byte(22'd2, 8'hC3, 1'b0);
    send_byte(22'd3, 8'hD4, 1'b0);
    wait_idle();
    check_word("hold0", wb, 21'd0, 16'hB2A1);
    check_word("hold1", wb + 1, 21'd1, 16'hD4C3);
    ioctl_download = 1'b0;
    wait_done(db);
    check("hold_size", {10'd0, dl_size}, 4);

    // Download falls with the final odd byte; done only after that word's ack
    wb = writes_q.size(); db = done_cnt;
    ioctl_download = 1'b1;
    step();
    send_byte(22'd0, 8'h11, 1'b0);
    send_byte(22'd1, 8'h22, 1'b0);
    send_byte(22'd2, 8'h33, 1'b0);
    ack_hold = 1'b1;
    send_byte(22'd3, 8'h44, 1'b1);
    repeat (20) step();
    check("late_no_done", done_cnt - db, 0);
    check("late_wait", {31'd0, ioctl_wait}, 1);
    ack_hold = 1'b0;
    wait_done(db);
    check_word("late0", wb, 21'd0, 16'h2211);
    check_word("late1", wb + 1, 21'd1, 16'h4433);
    check("late_size", {10'd0, dl_size}, 4);
    check("late_pulses", done_cnt - db, 1);

    // Reset during WAIT_ACK, then a fresh download
    ioctl_download = 1'b1;
    step();
    ack_hold = 1'b1;
    send_byte(22'd0, 8'h5A, 1'b0);
    send_byte(22'd1, 8'hA5, 1'b0);
    repeat (3) step();
    init_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("mid_rst_wait", {31'd0, ioctl_wait}, 0);
    check("mid_rst_req", {31'd0, rom_req}, 0);
    check("mid_rst_we", {31'd0, rom_we}, 0);
    check("mid_rst_din", {16'd0, rom_din}, 0);
    check("mid_rst_size", {10'd0, dl_size}, 0);
    step();
    init_n = 1'b1;
    ack_hold = 1'b0;
    step();
    check("post_rst_done", {31'd0, dl_done}, 0);
    for (int i = 0; i < 6; i++) img[i] = 8'(8'h90 + i);
    wb = writes_q.size(); db = done_cnt;
    run_download(0, 6, 1'b0);
    wait_done(db);
    check_image(0, 6, wb, db);

`ifdef ROM_BITREV_EN
    // Bit-reversed bytes
    wb = writes_q.size(); db = done_cnt;
    rom_bitrev = 1'b1;
    ioctl_download = 1'b1;
    step();
    send_byte(22'd0, 8'h01, 1'b0);
    send_byte(22'd1, 8'h80, 1'b0);
    wait_idle();
    check_word("bitrev", wb, 21'd0, 16'h0180);
    rom_bitrev = 1'b0;
    ioctl_download = 1'b0;
    wait_done(db);
`endif

    // Random images against the reference
    for (int r = 0; r < 12; r++) begin
      st = $urandom_range(0, 40);
      nn = $urandom_range(1, 12);
      sf = 1'($urandom_range(0, 1));
      ack_delay = $urandom_range(4, 9);
      for (int i = 0; i < nn; i++) img[i] = 8'($urandom);
      wb = writes_q.size(); db = done_cnt;
      run_download(st, nn, sf);
      wait_done(db);
      check_image(st, nn, wb, db);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
